fmm_reduce_kernel_sdiv_32s_32s_32_seq: RTL and testbench

FMM_REDUCE_KERNEL_SDIV_32S_32S_32_SEQ -- requirements
Module: fmm_reduce_kernel_sdiv_32s_32s_32_seq

---
 rtl/fmm_reduce_kernel_sdiv_32s_32s_32_seq.sv | 176 +++++++++++++++++
 tb/tb_fmm_reduce_kernel_sdiv_32s_32s_32_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmm_reduce_kernel_sdiv_32s_32s_32_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per cycle,
// then sign correction; valid/ready handshakes on both operand and result sides.
module fmm_reduce_kernel_sdiv_32s_32s_32_seq #(
  parameter int          ID         = 1,
  parameter int unsigned din0_WIDTH = 32,
  parameter int unsigned din1_WIDTH = 32,
  parameter int unsigned dout_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int unsigned W  = din0_WIDTH;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  // Operand and result widths must all match; ID is a tag only.
  if ((din1_WIDTH != din0_WIDTH) || (dout_WIDTH != din0_WIDTH) || (ID < 0)) begin : g_bad_params
    $error("fmm_reduce_kernel_sdiv_32s_32s_32_seq: invalid parameters");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0] prem_q, prem_d;
  logic [W-1:0] dvd_q, dvd_d;
  logic [W-1:0] dsr_q, dsr_d;
  logic [W-1:0] quot_q, quot_d;
  logic [W-1:0] rem_q, rem_d;
  logic         sign0_q, sign0_d;
  logic         sign1_q, sign1_d;
  logic         dz_q, dz_d;
  logic         dbz_q, dbz_d;

  logic         accept;
  logic         last_step;
  logic [W-1:0] din0_w, din1_w;
  logic [W-1:0] din0_mag, din1_mag;
  logic [W:0]   shifted, diff;
  logic         qbit;
  logic [W-1:0] prem_step, dvd_step;
  logic [W-1:0] quot_neg, rem_neg;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_step = (state_q == CALC) && (cnt_q == '0);

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and step counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = CW'(W - 1);
        end
      end
      CALC: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    quot        = quot_q;
    rem         = rem_q;
    div_by_zero = dbz_q;
  end

  // Datapath registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
      dz_q    <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      sign0_q <= sign0_d;
      sign1_q <= sign1_d;
      dz_q    <= dz_d;
      dbz_q   <= dbz_d;
    end
  end

  // Magnitudes: the most negative value maps onto itself, read as unsigned 2^(W-1)
  always_comb begin
    din0_w   = W'(din0);
    din1_w   = W'(din1);
    din0_mag = din0_w[W-1] ? -din0_w : din0_w;
    din1_mag = din1_w[W-1] ? -din1_w : din1_w;
  end

  // One restoring step; the dividend register drains from the top while quotient bits fill the bottom
  always_comb begin
    shifted   = {prem_q, dvd_q[W-1]};
    diff      = shifted - {1'b0, dsr_q};
    qbit      = ~diff[W];
    prem_step = qbit ? diff[W-1:0] : shifted[W-1:0];
    dvd_step  = {dvd_q[W-2:0], qbit};
    quot_neg  = -dvd_step;
    rem_neg   = -prem_step;
  end

  always_comb begin
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    sign0_d = sign0_q;
    sign1_d = sign1_q;
    dz_d    = dz_q;
    dbz_d   = dbz_q;
    if (accept) begin
      prem_d  = '0;
      dvd_d   = din0_mag;
      dsr_d   = din1_mag;
      sign0_d = din0_w[W-1];
      sign1_d = din1_w[W-1];
      dz_d    = (din1_w == '0);
    end else if (state_q == CALC) begin
      prem_d = prem_step;
      dvd_d  = dvd_step;
      if (last_step) begin
        // With a zero divisor every step succeeds, leaving |din0| as the remainder
        quot_d = dz_q ? '1 : ((sign0_q ^ sign1_q) ? quot_neg : dvd_step);
        rem_d  = sign0_q ? rem_neg : prem_step;
        dbz_d  = dz_q;
      end
    end
  end

endmodule

// File: tb/tb_fmm_reduce_kernel_sdiv_32s_32s_32_seq.sv
// Scoreboard bench for the sequential signed divider: directed corner cases plus randomized traffic.
module tb_fmm_reduce_kernel_sdiv_32s_32s_32_seq;

  localparam int W       = 32;
  localparam int LAT     = 32;
  localparam int N_RAND  = 1200;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int   errors = 0;
  int   checks = 0;
  exp_t scoreboard[$];

  fmm_reduce_kernel_sdiv_32s_32s_32_seq #(
    .ID(1), .din0_WIDTH(W), .din1_WIDTH(W), .dout_WIDTH(W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference: truncating C division/modulo with explicit zero and overflow cases
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa;
    int   sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = '0; e.dz = 1'b0;
    end else begin
      e.q = sa / sb; e.r = sa % sb; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge ap_clk); #1; n++;
    end
    ok = in_ready;
    if (!ok) return;
    in_valid = 1'b1; din0 = a; din1 = b;
    scoreboard.push_back(model(a, b));
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int edges, output bit ok);
    edges = 0;
    while (!out_valid && edges < budget) begin
      @(posedge ap_clk); #1; edges++;
    end
    ok = out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if (quot !== '0 || rem !== '0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got q=%h r=%h dz=%b want all zero", quot, rem, div_by_zero);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  // Directed operand table: signs, most-negative dividend, zero divisor and its recovery
  task automatic test_directed();
    logic [W-1:0] ta[7] = '{32'd100, -32'sd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'd1234, 32'd9};
    logic [W-1:0] tb[7] = '{32'd7, 32'd7, -32'sd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd3};
    logic [W-1:0] tq[7] = '{32'd14, -32'sd14, -32'sd14, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3};
    logic [W-1:0] tr[7] = '{32'd2, -32'sd2, 32'd2, 32'd0, 32'd0, 32'd1234, 32'd0};
    logic         tz[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    bit   ok;
    int   edges;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb[i], ok);
      wait_result(LAT + 8, edges, ok);
      checks++;
      if (!ok || edges != LAT) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges (valid=%b) want %0d", i, edges, ok, LAT);
      end
      e = scoreboard.pop_front();
      checks++;
      if (quot !== tq[i] || rem !== tr[i] || div_by_zero !== tz[i] || e.q !== tq[i] || e.r !== tr[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 i, quot, rem, div_by_zero, tq[i], tr[i], tz[i]);
      end
      consume();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_release[%0d]: got in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   ok;
    int   edges;
    issue(32'd77, -32'sd5, ok);
    wait_result(LAT + 8, edges, ok);
    e = scoreboard.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_timeout: got out_valid=%b want 1", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; din0 = $urandom; din1 = $urandom;
      @(posedge ap_clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== e.q || rem !== e.r || div_by_zero !== e.dz) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b q=%h r=%h dz=%b want v=1 rdy=0 q=%h r=%h dz=%b",
                 i, out_valid, in_ready, quot, rem, div_by_zero, e.q, e.r, e.dz);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== e.q || rem !== e.r) begin
      errors++;
      $display("FAIL bp_after: got rdy=%b v=%b q=%h r=%h want rdy=1 v=0 q=%h r=%h",
               in_ready, out_valid, quot, rem, e.q, e.r);
    end
  endtask

  task automatic test_reset_midcalc();
    exp_t e;
    bit   ok;
    int   edges;
    issue(32'd300, 32'd7, ok);
    repeat (15) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    void'(scoreboard.pop_back());
    #1;
    checks++;
    if (quot !== '0 || rem !== '0 || div_by_zero !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got q=%h r=%h dz=%b rdy=%b v=%b want 0 0 0 1 0",
               quot, rem, div_by_zero, in_ready, out_valid);
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    in_valid = 1'b1; din0 = 32'd50; din1 = 32'd5;
    scoreboard.push_back(model(32'd50, 32'd5));
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    wait_result(LAT + 8, edges, ok);
    e = scoreboard.pop_front();
    checks++;
    if (!ok || edges != LAT || quot !== 32'd10 || rem !== '0 || e.q !== 32'd10) begin
      errors++;
      $display("FAIL post_reset_op: got valid=%b edges=%0d q=%h r=%h want valid=1 edges=%0d q=0000000a r=0",
               ok, edges, quot, rem, LAT);
    end
    consume();
  endtask

  task automatic test_random();
    exp_t         e;
    bit           ok;
    int           edges;
    int           sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < N_RAND; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge ap_clk);
      #0;
      sel = $urandom_range(0, 15);
      a = (sel == 0) ? 32'h8000_0000 : W'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) a = -a;
      if (sel == 1)      b = '0;
      else if (sel == 2) b = 32'hFFFF_FFFF;
      else               b = W'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) b = -b;
      issue(a, b, ok);
      din0 = $urandom; din1 = $urandom;
      wait_result(LAT + 8, edges, ok);
      checks++;
      if (!ok || edges != LAT) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d edges (valid=%b) want %0d", i, edges, ok, LAT);
        break;
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge ap_clk); #1;
      end
      e = scoreboard.pop_front();
      checks++;
      if (quot !== e.q || rem !== e.r || div_by_zero !== e.dz) begin
        errors++;
        $display("FAIL rand_result[%0d] %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 i, a, b, quot, rem, div_by_zero, e.q, e.r, e.dz);
      end
      consume();
    end
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d pending results want 0", scoreboard.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midcalc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
